// File: rtl/dfh_chain_responder_if.sv
// dfh_chain_responder_if: AXI4-Lite CSR channel bundle between a host DFH walker and the responder
interface dfh_chain_responder_if #(
    parameter int ADDR_W = 20
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/dfh_chain_responder.sv
// dfh_chain_responder: AXI4-Lite target serving a linked DFH chain with one scratch register per feature
module dfh_chain_responder #(
    parameter int                     NUM_FEAT    = 4,
    parameter logic [31:0]            FEAT_STRIDE = 32'h1000,
    parameter int                     ADDR_W      = 20,
    parameter logic [NUM_FEAT*12-1:0] FEAT_IDS    = {12'h014, 12'h013, 12'h007, 12'h001},
    parameter logic [3:0]             FEAT_TYPE   = 4'h3,
    parameter logic [3:0]             MAJOR_VER   = 4'h0
) (
    input logic                  clk,
    input logic                  rst,
    dfh_chain_responder_if.slave bus
);
    localparam int SH = $clog2(FEAT_STRIDE);
    localparam int IW = NUM_FEAT > 1 ? $clog2(NUM_FEAT) : 1;
    typedef enum logic [1:0] {WIDLE, WCOMMIT, WRESP} wstate_t;
    typedef enum logic {RIDLE, RRESP} rstate_t;
    wstate_t           w_state, w_next;
    rstate_t           r_state, r_next;
    logic              aw_held, w_held, aw_fire, w_fire, ar_fire;
    logic [ADDR_W-1:0] waddr;
    logic [63:0]       wdata_q;
    logic [7:0]        wstrb_q;
    logic [63:0]       scratch [NUM_FEAT];

    function automatic logic [ADDR_W-1:0] feat_idx(input logic [ADDR_W-1:0] a);
        return a >> SH;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return feat_idx(a) < ADDR_W'(NUM_FEAT);
    endfunction

    // 8-byte slot within the feature window; 0 is the DFH, 1 the scratch register
    function automatic logic [SH-4:0] slot(input logic [ADDR_W-1:0] a);
        return (SH-3)'((a & ADDR_W'(FEAT_STRIDE - 1)) >> 3);
    endfunction

    function automatic logic [65:0] lookup(input logic [ADDR_W-1:0] a);
        logic [IW-1:0] i;
        logic          last;
        i    = IW'(feat_idx(a));
        last = feat_idx(a) == ADDR_W'(NUM_FEAT - 1);
        if (!in_range(a)) return {2'b10, 64'h0};
        if (slot(a) == '0)
            return {2'b00, FEAT_TYPE, 19'h0, last, last ? 24'h0 : FEAT_STRIDE[23:0], MAJOR_VER, FEAT_IDS[i*12 +: 12]};
        if (slot(a) == (SH-3)'(1)) return {2'b00, scratch[i]};
        return '0;
    endfunction

    always_comb begin
        bus.awready = !rst && w_state == WIDLE && !aw_held;
        bus.wready  = !rst && w_state == WIDLE && !w_held;
        bus.bvalid  = w_state == WRESP;
        bus.arready = !rst && r_state == RIDLE;
        bus.rvalid  = r_state == RRESP;
        aw_fire     = bus.awvalid && bus.awready;
        w_fire      = bus.wvalid && bus.wready;
        ar_fire     = bus.arvalid && bus.arready;
        w_next      = w_state == WCOMMIT ? WRESP :
                      w_state == WRESP   ? (bus.bready ? WIDLE : WRESP) :
                      ((aw_held || aw_fire) && (w_held || w_fire) ? WCOMMIT : WIDLE);
        r_next      = r_state == RRESP ? (bus.rready ? RIDLE : RRESP) : (ar_fire ? RRESP : RIDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= WIDLE;
            r_state <= RIDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Read decode samples scratch before this edge's commit, so a colliding read sees the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held                 <= 1'b0;
            w_held                  <= 1'b0;
            waddr                   <= '0;
            wdata_q                 <= '0;
            wstrb_q                 <= '0;
            bus.bresp               <= 2'b00;
            {bus.rresp, bus.rdata}  <= '0;
            for (int i = 0; i < NUM_FEAT; i++) scratch[i] <= '0;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                waddr   <= bus.awaddr;
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (w_state == WCOMMIT) begin
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                bus.bresp <= in_range(waddr) ? 2'b00 : 2'b10;
                if (in_range(waddr) && slot(waddr) == (SH-3)'(1))
                    for (int b = 0; b < 8; b++)
                        if (wstrb_q[b]) scratch[IW'(feat_idx(waddr))][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
            if (ar_fire) {bus.rresp, bus.rdata} <= lookup(bus.araddr);
        end
    end
endmodule

// File: tb/tb_dfh_chain_responder.sv
// tb_dfh_chain_responder: randomized AXI4-Lite traffic checked every cycle against a transaction-level model
module tb_dfh_chain_responder;
    localparam int NF = 4;
    localparam int ST = 'h1000;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfh_chain_responder_if #(.ADDR_W(AW)) bus ();
    dfh_chain_responder #(.NUM_FEAT(NF), .FEAT_STRIDE(ST), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    int          rbp = 0;
    int          bbp = 0;
    int          ids [NF] = '{'h001, 'h007, 'h013, 'h014};
    logic [63:0] walk [NF] = '{64'h3000_0000_1000_0001, 64'h3000_0000_1000_0007,
                                64'h3000_0000_1000_0013, 64'h3000_0100_0000_0014};
    logic [63:0] m_scr [NF];
    bit          r_out, b_out, c_pend, aw_got, w_got;
    logic [65:0] r_exp;
    logic [1:0]  b_exp;
    logic [AW-1:0] m_wa;
    logic [63:0] m_wd;
    logic [7:0]  m_ws;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [63:0] dfh(input int i);
        logic [63:0] d;
        d = 64'(3) << 60;
        d = d | ((i == NF - 1) ? (64'd1 << 40) : (64'(ST) << 16));
        return d | 64'(ids[i]);
    endfunction

    function automatic logic [65:0] m_read(input int a);
        int i, off;
        i   = a / ST;
        off = (a % ST) & ~7;
        if (i >= NF) return {2'b10, 64'd0};
        if (off == 0) return {2'b00, dfh(i)};
        if (off == 8) return {2'b00, m_scr[i]};
        return '0;
    endfunction

    task automatic m_write();
        int i, off;
        i     = int'(m_wa) / ST;
        off   = (int'(m_wa) % ST) & ~7;
        b_exp = i >= NF ? 2'b10 : 2'b00;
        if (i < NF && off == 8)
            for (int b = 0; b < 8; b++)
                if (m_ws[b]) m_scr[i][b*8 +: 8] = m_wd[b*8 +: 8];
    endtask

    // One call per cycle at the falling edge: check outputs, then advance the model past the next rising edge
    task automatic step();
        bit busy;
        busy = c_pend || b_out;
        if (rst) begin
            chk("rst_awready", bus.awready, 0);
            chk("rst_wready", bus.wready, 0);
            chk("rst_arready", bus.arready, 0);
            chk("rst_bvalid", bus.bvalid, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_resps", {bus.bresp, bus.rresp}, 0);
            r_out = 0; b_out = 0; c_pend = 0; aw_got = 0; w_got = 0;
            for (int i = 0; i < NF; i++) m_scr[i] = '0;
            return;
        end
        chk("arready", bus.arready, !r_out);
        chk("rvalid", bus.rvalid, r_out);
        if (r_out) begin
            chk("rdata", bus.rdata, r_exp[63:0]);
            chk("rresp", bus.rresp, r_exp[65:64]);
        end
        chk("awready", bus.awready, !busy && !aw_got);
        chk("wready", bus.wready, !busy && !w_got);
        chk("bvalid", bus.bvalid, b_out);
        if (b_out) chk("bresp", bus.bresp, b_exp);
        if (r_out) begin
            if (bus.rready) r_out = 0;
        end else if (bus.arvalid) begin
            r_out = 1;
            r_exp = m_read(int'(bus.araddr));
        end
        if (c_pend) begin
            m_write();
            c_pend = 0;
            b_out  = 1;
        end else if (b_out) begin
            if (bus.bready) b_out = 0;
        end else begin
            if (bus.awvalid && !aw_got) begin aw_got = 1; m_wa = bus.awaddr; end
            if (bus.wvalid && !w_got) begin w_got = 1; m_wd = bus.wdata; m_ws = bus.wstrb; end
            if (aw_got && w_got) begin c_pend = 1; aw_got = 0; w_got = 0; end
        end
    endtask

    function automatic bit sig(input int k);
        return k == 0 ? bus.awready : k == 1 ? bus.wready : k == 2 ? bus.arready :
               k == 3 ? bus.rvalid : k == 4 ? (bus.rvalid && bus.rready) :
               k == 5 ? bus.bvalid : (bus.bvalid && bus.bready);
    endfunction

    task automatic wait_for(input int k, input string nm, output int n);
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (sig(k)) return;
        end
        tmo(nm);
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int d);
        int n;
        repeat (d) @(posedge clk);
        #1 bus.awvalid = 1; bus.awaddr = a;
        wait_for(0, "awready", n);
        @(posedge clk);
        #1 bus.awvalid = 0;
    endtask

    task automatic send_w(input logic [63:0] v, input logic [7:0] s, input int d);
        int n;
        repeat (d) @(posedge clk);
        #1 bus.wvalid = 1; bus.wdata = v; bus.wstrb = s;
        wait_for(1, "wready", n);
        @(posedge clk);
        #1 bus.wvalid = 0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        int n;
        #1 bus.arvalid = 1; bus.araddr = a;
        wait_for(2, "arready", n);
        @(posedge clk);
        #1 bus.arvalid = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [63:0] d, output logic [1:0] r, output int lat);
        int n;
        send_ar(a);
        wait_for(3, "rvalid", lat);
        if (!bus.rready) wait_for(4, "r_handshake", n);
        d = bus.rdata;
        r = bus.rresp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] v, input logic [7:0] s,
                            input int daw, input int dw, output logic [1:0] br, output int lat);
        int n;
        fork
            send_aw(a, daw);
            send_w(v, s, dw);
        join
        wait_for(5, "bvalid", lat);
        if (!bus.bready) wait_for(6, "b_handshake", n);
        br = bus.bresp;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sel, o;
        sel = $urandom_range(0, 3);
        o   = sel == 0 ? 0 : sel == 3 ? ($urandom_range(0, ST - 1) & ~7) : 8;
        return AW'($urandom_range(0, 5) * ST + o + $urandom_range(0, 7));
    endfunction

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.awaddr, bus.araddr, bus.wdata, bus.wstrb} = '0;
        bus.rready = 1;
        bus.bready = 1;
        fork
            forever begin @(negedge clk); step(); end
            forever begin
                @(posedge clk);
                #1;
                bus.rready = rbp == 0 ? 1'b1 : rbp == 1 ? 1'($urandom) : 1'b0;
                bus.bready = bbp == 0 ? 1'b1 : bbp == 1 ? 1'($urandom) : 1'b0;
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < NF; i++) begin
            do_read(AW'(i * ST), d, r, lat);
            chk($sformatf("walk%0d_data", i), d, walk[i]);
            chk($sformatf("walk%0d_resp", i), r, 0);
            chk($sformatf("walk%0d_lat", i), lat, 1);
        end
        do_write(20'h2008, 64'hDEAD_BEEF_0123_4567, 8'h0F, 0, 0, r, lat);
        chk("strb_lo_bresp", r, 0);
        chk("strb_lo_lat", lat, 2);
        do_read(20'h2008, d, r, lat);
        chk("strb_lo_data", d, 64'h0000_0000_0123_4567);
        do_write(20'h2008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 0, 0, r, lat);
        do_read(20'h2008, d, r, lat);
        chk("strb_hi_data", d, 64'hFFFF_FFFF_0123_4567);
        do_write(20'h1000, 64'h0, 8'hFF, 0, 0, r, lat);
        chk("dfh_wr_bresp", r, 0);
        do_read(20'h1000, d, r, lat);
        chk("dfh_wr_data", d, 64'h3000_0000_1000_0007);
        do_read(20'h4000, d, r, lat);
        chk("oor_rdata", d, 0);
        chk("oor_rresp", r, 2);
        do_write(20'h4008, 64'h1234, 8'hFF, 0, 0, r, lat);
        chk("oor_bresp", r, 2);
        do_read(20'h2008, d, r, lat);
        chk("oor_noside", d, 64'hFFFF_FFFF_0123_4567);
        do_write(20'h0008, 64'h11, 8'hFF, 3, 0, r, lat);
        chk("w_first_lat", lat, 2);
        do_read(20'h0008, d, r, lat);
        chk("w_first_data", d, 64'h11);
        rbp = 2;
        @(posedge clk);
        send_ar(20'h1000);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rvalid", bus.rvalid, 1);
            chk("bp_arready", bus.arready, 0);
            chk("bp_rdata", bus.rdata, 64'h3000_0000_1000_0007);
        end
        rbp = 0;
        wait_for(4, "bp_drain", lat);
        @(posedge clk);
        bbp = 2;
        @(posedge clk);
        #1;
        fork
            send_aw(20'h2008, 0);
            send_w(64'hABCD, 8'hFF, 0);
        join
        wait_for(5, "rst_bvalid_wait", lat);
        @(posedge clk);
        #1 rst = 1;
        #1 chk("rst_bvalid_now", bus.bvalid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0; bbp = 0;
        do_read(20'h2008, d, r, lat);
        chk("rst_scratch", d, 0);
        bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 20'h8; bus.wdata = 64'd5; bus.wstrb = 8'hFF;
        @(posedge clk);
        #1 bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 1; bus.araddr = 20'h8;
        @(posedge clk);
        #1 bus.arvalid = 0;
        wait_for(3, "coll_rvalid", lat);
        chk("coll_old", bus.rdata, 0);
        @(posedge clk);
        #1;
        do_read(20'h0008, d, r, lat);
        chk("coll_new", d, 64'd5);
        rbp = 1;
        bbp = 1;
        fork
            begin
                logic [63:0] rd_d;
                logic [1:0]  rd_r;
                int          rd_l;
                repeat (80) do_read(rand_addr(), rd_d, rd_r, rd_l);
            end
            begin
                logic [1:0] wr_r;
                int         wr_l;
                repeat (80) do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom),
                                     $urandom_range(0, 3), $urandom_range(0, 3), wr_r, wr_l);
            end
        join
        rbp = 0;
        bbp = 0;
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
